fp_mul_pipe: RTL and testbench

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

---
 rtl/fp_mul_pipe.sv | 166 ++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: pipelined IEEE-754 single-precision multiplier with valid/ready handshake.
//
// The product is computed combinationally from a/b. It then travels with its tag through
// STAGES register stages, so latency is exactly STAGES cycles. All stages advance together
// whenever the output slot is empty or being consumed. Bubbles are kept in place and are
// not compressed.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake; in_ready is combinational (= advance)
//   a, b, in_tag         operands and opaque sideband tag
//   out_valid/out_ready  output handshake
//   result, out_tag      product and the tag of that operation
//   flags                {NV,DZ,OF,UF,NX}; DZ is always 0
//
// Build option: define FP_MUL_PIPE_RNE_EN for round-to-nearest-even (overflow -> inf).
// Without it, results are truncated (overflow -> max finite).
// Subnormal inputs are treated as signed zero. Results that would be subnormal flush to zero.
// STAGES must be in the range 1..4.

module fp_mul_pipe #(
    parameter int unsigned STAGES = 3,
    parameter int unsigned TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       flags
);

    // Operand decode
    logic        sgn;
    logic [7:0]  exp_a, exp_b;
    logic [22:0] frac_a, frac_b;
    logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b;

    assign sgn    = a[31] ^ b[31];
    assign exp_a  = a[30:23];
    assign exp_b  = b[30:23];
    assign frac_a = a[22:0];
    assign frac_b = b[22:0];
    // A zero exponent covers both true zero and subnormals.
    assign zero_a = (exp_a == 8'h00);
    assign zero_b = (exp_b == 8'h00);
    assign inf_a  = (exp_a == 8'hFF) && (frac_a == 23'h0);
    assign inf_b  = (exp_b == 8'hFF) && (frac_b == 23'h0);
    assign nan_a  = (exp_a == 8'hFF) && (frac_a != 23'h0);
    assign nan_b  = (exp_b == 8'hFF) && (frac_b != 23'h0);
    assign snan_a = nan_a && !frac_a[22];
    assign snan_b = nan_b && !frac_b[22];

    // Mantissa product and exponent sum
    logic        [47:0] prod;
    logic signed [9:0]  exp_raw;

    assign prod    = {24'h0, 1'b1, frac_a} * {24'h0, 1'b1, frac_b};
    assign exp_raw = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;

    logic signed [9:0]  exp_n, exp_f;
    logic        [22:0] frac, frac_f;
    logic               grd, sticky;
    logic        [31:0] ovf_res;
    logic        [31:0] res_c;
    logic        [4:0]  flg_c;
`ifdef FP_MUL_PIPE_RNE_EN
    logic               inc;
    logic        [24:0] rnd;
`endif

    always_comb begin
        exp_n   = exp_raw;
        frac    = prod[45:23];
        grd     = prod[22];
        sticky  = |prod[21:0];
        res_c   = 32'h0;
        flg_c   = 5'h0;
        // Product in [2,4): shift right by one and bump the exponent.
        if (prod[47]) begin
            exp_n  = exp_raw + 10'sd1;
            frac   = prod[46:24];
            grd    = prod[23];
            sticky = |prod[22:0];
        end
`ifdef FP_MUL_PIPE_RNE_EN
        inc = grd && (sticky || frac[0]);
        rnd = {2'b01, frac} + {24'h0, inc};
        // Rounding carried past the hidden bit: renormalise.
        if (rnd[24]) begin
            exp_f  = exp_n + 10'sd1;
            frac_f = rnd[23:1];
        end else begin
            exp_f  = exp_n;
            frac_f = rnd[22:0];
        end
        ovf_res = {sgn, 8'hFF, 23'h0};
`else
        exp_f   = exp_n;
        frac_f  = frac;
        ovf_res = {sgn, 31'h7F7FFFFF};
`endif
        if (nan_a || nan_b) begin
            res_c    = 32'h7FC00000;
            flg_c[4] = snan_a || snan_b;
        end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
            res_c = 32'h7FC00000;
            flg_c = 5'b10000;
        end else if (zero_a || zero_b) begin
            res_c = {sgn, 31'h0};
        end else if (inf_a || inf_b) begin
            res_c = {sgn, 8'hFF, 23'h0};
        end else if (exp_f >= 10'sd255) begin
            res_c = ovf_res;
            flg_c = 5'b00101;
        end else if (exp_f <= 10'sd0) begin
            res_c = {sgn, 31'h0};
            flg_c = 5'b00011;
        end else begin
            res_c = {sgn, exp_f[7:0], frac_f};
            flg_c = {4'b0000, grd | sticky};
        end
    end

    // Pipeline
    logic                           adv;
    logic [STAGES-1:0]              vld_q;
    logic [STAGES-1:0][31:0]        res_q;
    logic [STAGES-1:0][4:0]         flg_q;
    logic [STAGES-1:0][TAG_W-1:0]   tag_q;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            res_q <= '0;
            flg_q <= '0;
            tag_q <= '0;
        end else if (adv) begin
            vld_q[0] <= in_valid;
            res_q[0] <= res_c;
            flg_q[0] <= flg_c;
            tag_q[0] <= in_tag;
            for (int i = 1; i < int'(STAGES); i++) begin
                vld_q[i] <= vld_q[i-1];
                res_q[i] <= res_q[i-1];
                flg_q[i] <= flg_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign result    = res_q[STAGES-1];
    assign flags     = flg_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe: directed vectors with hand-derived results, a
// scoreboard queue of expected outputs, handshake stall checks and mid-flight reset.
// Expected values follow FP_MUL_PIPE_RNE_EN in the same way as the design.

module tb_fp_mul_pipe;

    localparam int STAGES = 3;
    localparam int TAG_W  = 5;
    localparam int NVEC   = 18;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      result;
    logic [TAG_W-1:0] out_tag;
    logic [4:0]       flags;

    fp_mul_pipe #(
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // a, b, result (RNE), result (truncate), flags (RNE), flags (truncate)
    typedef struct packed {
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] r_rne;
        logic [31:0] r_rtz;
        logic [4:0]  f_rne;
        logic [4:0]  f_rtz;
    } vec_t;

    vec_t vecs [NVEC] = '{
        '{32'h40400000, 32'h40000000, 32'h40C00000, 32'h40C00000, 5'h00, 5'h00},
        '{32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 5'h10, 5'h10},
        '{32'h7FA00000, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 5'h10, 5'h10},
        '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 32'h3FC00001, 5'h01, 5'h01},
        '{32'h7F000000, 32'h40000000, 32'h7F800000, 32'h7F7FFFFF, 5'h05, 5'h05},
        '{32'h00800000, 32'h3F000000, 32'h00000000, 32'h00000000, 5'h03, 5'h03},
        '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 5'h00, 5'h00},
        '{32'hC0000000, 32'h40400000, 32'hC0C00000, 32'hC0C00000, 5'h00, 5'h00},
        '{32'h80000001, 32'h3F800000, 32'h80000000, 32'h80000000, 5'h00, 5'h00},
        '{32'hFF800000, 32'h40000000, 32'hFF800000, 32'hFF800000, 5'h00, 5'h00},
        '{32'h80000000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, 5'h10, 5'h10},
        '{32'h7FC00000, 32'h7F800001, 32'h7FC00000, 32'h7FC00000, 5'h10, 5'h10},
        '{32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 32'h3FFFFFFF, 5'h01, 5'h01},
        '{32'h7F7FFFFE, 32'h3F800001, 32'h7F800000, 32'h7F7FFFFF, 5'h05, 5'h01},
        '{32'h00800000, 32'h3F800000, 32'h00800000, 32'h00800000, 5'h00, 5'h00},
        '{32'h80800000, 32'h3F000000, 32'h80000000, 32'h80000000, 5'h03, 5'h03},
        '{32'hFF000000, 32'h40000000, 32'hFF800000, 32'hFF7FFFFF, 5'h05, 5'h05},
        '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 32'h407FFFFE, 5'h01, 5'h01}
    };

    typedef struct {
        logic [31:0]      res;
        logic [4:0]       flg;
        logic [TAG_W-1:0] tag;
        int               t_in;
        bit               lat;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;

    int n_vec = 0;
    int n_bad = 0;
    bit rand_done;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Drive one operation and wait for it to be accepted; push its expectation on transfer.
    task automatic send(input logic [31:0] va, input logic [31:0] vb,
                        input logic [TAG_W-1:0] vt, input logic [31:0] er,
                        input logic [4:0] ef, input bit lat);
        int   waited = 0;
        bit   done_s = 0;
        exp_t e;
        a        = va;
        b        = vb;
        in_tag   = vt;
        in_valid = 1'b1;
        while (!done_s) begin
            @(negedge clk);
            if (in_ready) begin
                e.res  = er;
                e.flg  = ef;
                e.tag  = vt;
                e.t_in = cyc;
                e.lat  = lat;
                sb.push_back(e);
                done_s = 1;
            end else begin
                waited++;
                if (waited > 50) begin
                    check_eq("send_timeout", 32'(in_ready), 32'd1);
                    done_s = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input int i, input logic [TAG_W-1:0] vt, input bit lat);
`ifdef FP_MUL_PIPE_RNE_EN
        send(vecs[i].va, vecs[i].vb, vt, vecs[i].r_rne, vecs[i].f_rne, lat);
`else
        send(vecs[i].va, vecs[i].vb, vt, vecs[i].r_rtz, vecs[i].f_rtz, lat);
`endif
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({name, "_in_ready"}, 32'(in_ready), 32'd1);
        check_eq({name, "_result"}, result, 32'h0);
        check_eq({name, "_flags"}, 32'(flags), 32'h0);
        check_eq({name, "_tag"}, 32'(out_tag), 32'h0);
    endtask

    // Output monitor: every transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("result", result, mon_e.res);
                check_eq("flags", 32'(flags), 32'(mon_e.flg));
                check_eq("tag", 32'(out_tag), 32'(mon_e.tag));
                if (mon_e.lat) check_eq("latency", 32'(cyc - mon_e.t_in), 32'(STAGES));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 32'h0;
        b         = 32'h0;
        in_tag    = '0;
        out_ready = 1'b1;
        rand_done = 1'b0;
        #1;
        check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single operation, latency and tag echo.
        send_vec(0, 5'd5, 1'b1);
        drain();

        // All vectors back to back at full throughput.
        for (int i = 0; i < NVEC; i++) send_vec(i, 5'(i), 1'b1);
        drain();

        // Tags 1..6 with the consumer stalled for 3 cycles at the first result.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_vec(i, 5'(i + 1), 1'b0);
            end
            begin
                int w = 0;
                logic [31:0] hr;
                logic [4:0]  hf;
                logic [TAG_W-1:0] ht;
                @(negedge clk);
                while (!out_valid && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                check_eq("stall_seen", 32'(out_valid), 32'd1);
                hr = (sb.size() > 0) ? sb[0].res : 32'h0;
                hf = (sb.size() > 0) ? sb[0].flg : 5'h0;
                ht = (sb.size() > 0) ? sb[0].tag : '0;
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) @(negedge clk);
                    check_eq("stall_in_ready", 32'(in_ready), 32'd0);
                    check_eq("stall_out_valid", 32'(out_valid), 32'd1);
                    check_eq("stall_result", result, hr);
                    check_eq("stall_flags", 32'(flags), 32'(hf));
                    check_eq("stall_tag", 32'(out_tag), 32'd1);
                    check_eq("stall_tag_sb", 32'(out_tag), 32'(ht));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two operations in flight.
        send_vec(7, 5'd7, 1'b0);
        send_vec(3, 5'd8, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        @(negedge clk);
        check_reset_outputs("midrst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_eq("post_rst_idle", 32'(out_valid), 32'd0);
        send_vec(7, 5'd9, 1'b1);
        drain();

        // Random consumer back-pressure over the full vector set.
        fork
            begin
                for (int i = 0; i < NVEC; i++) send_vec(i, 5'(i + 10), 1'b0);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
